// File: rtl/irq_priority_encoder.sv
// Eight-level priority interrupt encoder for an 8080 core: synchronizes active-low
// requests, raises INT for the highest accepted level and serves an RST n opcode on INTA.
module irq_priority_encoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req_n,
  input  logic       en_n,
  input  logic       inta_n,
  input  logic       eoi,
  output logic       int_n,
  output logic [2:0] code_n,
  output logic       gs_n,
  output logic       eo_n,
  output logic [7:0] rst_opcode,
  output logic       opcode_oe
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] w_req;
  logic [7:0] w_accepted;
  logic [2:0] w_winner;
  logic       w_any;
  logic       w_take;
  logic       w_retire;
  logic [2:0] r_cap_level;
  logic [2:0] r_is_level;
  logic       r_is_valid;
  logic [2:0] r_code_n;
  logic       r_gs_n;
  logic       r_eo_n;
  logic       r_int_n;
  logic       r_opcode_oe;

  // NOTE: synchronizer flops reset to 1 (no request), so leaving reset never fakes an interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 8'hFF;
    end else begin
      r_sync[0] <= req_n;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_req = ~r_sync[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_accepted = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_req[i] && !en_n && (!r_is_valid || 3'(i) > r_is_level)) w_accepted[i] = 1'b1;
    end
  end

  // Ascending scan: the last hit, i.e. the highest level, wins.
  always_comb begin
    w_winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_accepted[i]) w_winner = 3'(i);
    end
  end

  assign w_any = |w_accepted;

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code_n <= 3'b111;
      r_gs_n   <= 1'b1;
      r_eo_n   <= 1'b1;
    end else begin
      r_code_n <= w_any ? ~w_winner : 3'b111;
      r_gs_n   <= ~w_any;
      r_eo_n   <= ~(!en_n && (&r_sync[SYNC_STAGES-1]));
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any)   w_state_next = ST_REQ;
      ST_REQ:  if (!inta_n) w_state_next = ST_ACK;
      ST_ACK:  if (inta_n)  w_state_next = ST_IDLE;
      default:              w_state_next = ST_IDLE;
    endcase
  end

  assign w_take   = (r_state == ST_IDLE) && w_any;
  assign w_retire = (r_state == ST_ACK) && inta_n;

  // int_n and opcode_oe are registered from the next state so they never glitch on a
  // two-bit state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_int_n     <= 1'b1;
      r_opcode_oe <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_int_n     <= (w_state_next != ST_REQ);
      r_opcode_oe <= (w_state_next == ST_ACK);
    end
  end

  // Retirement wins over a coincident eoi: the new level is installed as valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_level <= 3'd7;
      r_is_level  <= 3'd0;
      r_is_valid  <= 1'b0;
    end else begin
      if (w_take) r_cap_level <= w_winner;
      if (w_retire) begin
        r_is_level <= r_cap_level;
        r_is_valid <= 1'b1;
      end else if (eoi) begin
        r_is_valid <= 1'b0;
      end
    end
  end

  assign int_n      = r_int_n;
  assign opcode_oe  = r_opcode_oe;
  assign code_n     = r_code_n;
  assign gs_n       = r_gs_n;
  assign eo_n       = r_eo_n;
  assign rst_opcode = {2'b11, r_cap_level, 3'b111};

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Scoreboard bench for irq_priority_encoder: a behavioural model queues the expected
// outputs per clock, a monitor pops and compares them on the falling edge.
module tb_irq_priority_encoder;
  localparam int SYNC_STAGES = 2;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] req_n  = 8'hFF;
  logic       en_n   = 1'b0;
  logic       inta_n = 1'b1;
  logic       eoi    = 1'b0;
  logic       int_n;
  logic [2:0] code_n;
  logic       gs_n;
  logic       eo_n;
  logic [7:0] rst_opcode;
  logic       opcode_oe;

  irq_priority_encoder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .req_n(req_n), .en_n(en_n), .inta_n(inta_n), .eoi(eoi),
    .int_n(int_n), .code_n(code_n), .gs_n(gs_n), .eo_n(eo_n),
    .rst_opcode(rst_opcode), .opcode_oe(opcode_oe)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: phase 0 = quiet, 1 = interrupt raised, 2 = being acknowledged.
  logic [7:0]  m_sync[$];
  int          m_phase = 0;
  int          m_cap   = 7;
  int          m_isl   = 0;
  bit          m_isv   = 1'b0;
  logic [2:0]  m_code_n = 3'b111;
  logic        m_gs_n  = 1'b1;
  logic        m_eo_n  = 1'b1;
  logic [14:0] exp_q[$];

  function automatic int pick(input logic [7:0] s_n, input logic en, input bit isv, input int isl);
    for (int l = 7; l >= 0; l--)
      if (!s_n[l] && !en && (!isv || l > isl)) return l;
    return -1;
  endfunction

  task automatic model_edge();
    int         w;
    logic [7:0] s;
    bit         retire;
    if (reset) begin
      m_sync.delete();
      repeat (SYNC_STAGES) m_sync.push_back(8'hFF);
      m_phase = 0; m_cap = 7; m_isl = 0; m_isv = 1'b0;
      m_code_n = 3'b111; m_gs_n = 1'b1; m_eo_n = 1'b1;
    end else begin
      s = m_sync[$];
      w = pick(s, en_n, m_isv, m_isl);
      m_code_n = (w < 0) ? 3'b111 : ~3'(w);
      m_gs_n   = (w < 0);
      m_eo_n   = !(en_n == 1'b0 && s == 8'hFF);
      retire   = (m_phase == 2) && inta_n;
      case (m_phase)
        0: if (w >= 0) begin m_phase = 1; m_cap = w; end
        1: if (!inta_n) m_phase = 2;
        default: if (inta_n) m_phase = 0;
      endcase
      if (eoi) m_isv = 1'b0;
      if (retire) begin m_isl = m_cap; m_isv = 1'b1; end
      m_sync.push_front(req_n);
      void'(m_sync.pop_back());
    end
    exp_q.push_back({m_phase != 1, m_code_n, m_gs_n, m_eo_n,
                     2'b11, 3'(m_cap), 3'b111, m_phase == 2});
  endtask

  logic [14:0] mon_exp;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("cycle_outputs", {17'd0, int_n, code_n, gs_n, eo_n, rst_opcode, opcode_oe},
            {17'd0, mon_exp});
    end
  end

  task automatic cycle(input logic [7:0] r, input logic e, input logic a, input logic o,
                       input logic rs);
    req_n = r; en_n = e; inta_n = a; eoi = o; reset = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic hold(input int n, input logic [7:0] r);
    repeat (n) cycle(r, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Drop all requests, let the pipeline drain, then clear the in-service level.
  task automatic clear_service();
    hold(3, 8'hFF);
    cycle(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(1, 8'hFF);
  endtask

  logic [7:0] rnd_req = 8'hFF;
  logic       rnd_en  = 1'b0;

  initial begin
    // Reset values
    cycle(8'hFF, 0, 1, 0, 1);
    cycle(8'hFF, 0, 1, 0, 1);
    check("rst_int_n", int_n, 1'b1);
    check("rst_code_n", code_n, 3'b111);
    check("rst_gs_n", gs_n, 1'b1);
    check("rst_eo_n", eo_n, 1'b1);
    check("rst_opcode", rst_opcode, 8'hFF);
    check("rst_oe", opcode_oe, 1'b0);
    hold(1, 8'hFF);

    // Single request at level 2, two-flop latency then acknowledge for two cycles
    hold(2, 8'hFB);
    check("lat_not_early", int_n, 1'b1);
    hold(1, 8'hFB);
    check("single_int_n", int_n, 1'b0);
    check("single_code_n", code_n, 3'b101);
    check("single_gs_n", gs_n, 1'b0);
    check("single_opcode", rst_opcode, 8'hD7);
    cycle(8'hFB, 0, 0, 0, 0);
    check("ack_oe", opcode_oe, 1'b1);
    check("ack_int_n", int_n, 1'b1);
    cycle(8'hFB, 0, 0, 0, 0);
    check("ack_oe_2nd", opcode_oe, 1'b1);
    cycle(8'hFB, 0, 1, 0, 0);
    check("ack_oe_fall", opcode_oe, 1'b0);
    hold(3, 8'hFB);
    check("same_level_masked", int_n, 1'b1);
    clear_service();

    // Priority and freeze of the captured level
    hold(3, 8'h7E);
    check("prio_opcode", rst_opcode, 8'hFF);
    check("prio_code_n", code_n, 3'b000);
    hold(1, 8'hFD); hold(1, 8'hFF); hold(1, 8'h00); hold(1, 8'hFF);
    check("freeze_opcode", rst_opcode, 8'hFF);
    check("freeze_int_n", int_n, 1'b0);
    cycle(8'hFF, 0, 0, 0, 0);
    cycle(8'hFF, 0, 1, 0, 0);
    clear_service();

    // Masking by the in-service level
    hold(3, 8'hDF);
    check("lvl5_opcode", rst_opcode, 8'hEF);
    cycle(8'hDF, 0, 0, 0, 0);
    cycle(8'hDF, 0, 1, 0, 0);
    hold(4, 8'hF7);
    check("mask_int_n", int_n, 1'b1);
    check("mask_gs_n", gs_n, 1'b1);
    check("mask_eo_n", eo_n, 1'b1);
    hold(3, 8'hB7);
    check("lvl6_int_n", int_n, 1'b0);
    check("lvl6_opcode", rst_opcode, 8'hF7);
    cycle(8'hB7, 0, 1, 1, 0);
    cycle(8'hB7, 0, 0, 0, 0);
    cycle(8'hF7, 0, 1, 0, 0);
    hold(4, 8'hF7);
    check("lvl3_still_masked", int_n, 1'b1);
    cycle(8'hF7, 0, 1, 1, 0);
    check("eoi_not_same_edge", int_n, 1'b1);
    hold(1, 8'hF7);
    check("eoi_unmask_int_n", int_n, 1'b0);
    check("eoi_unmask_opcode", rst_opcode, 8'hDF);
    cycle(8'hF7, 0, 0, 0, 0);
    cycle(8'hFF, 0, 1, 0, 0);
    clear_service();

    // Enable and cascade output
    repeat (4) cycle(8'hEF, 1, 1, 0, 0);
    check("dis_int_n", int_n, 1'b1);
    check("dis_gs_n", gs_n, 1'b1);
    check("dis_eo_n", eo_n, 1'b1);
    repeat (3) cycle(8'hFF, 1, 1, 0, 0);
    cycle(8'hFF, 0, 1, 0, 0);
    check("cascade_eo_n", eo_n, 1'b0);

    // Reset while acknowledging, then re-raise from the held request
    hold(3, 8'hFB);
    cycle(8'hFB, 0, 0, 0, 0);
    check("pre_rst_oe", opcode_oe, 1'b1);
    cycle(8'hFB, 0, 0, 0, 1);
    check("midack_int_n", int_n, 1'b1);
    check("midack_code_n", code_n, 3'b111);
    check("midack_gs_n", gs_n, 1'b1);
    check("midack_eo_n", eo_n, 1'b1);
    check("midack_opcode", rst_opcode, 8'hFF);
    check("midack_oe", opcode_oe, 1'b0);
    hold(2, 8'hFB);
    check("rerise_not_early", int_n, 1'b1);
    hold(1, 8'hFB);
    check("rerise_int_n", int_n, 1'b0);
    check("rerise_opcode", rst_opcode, 8'hD7);

    // eoi coinciding with the acknowledge end installs the new level as valid
    cycle(8'hFB, 0, 0, 0, 0);
    cycle(8'hF9, 0, 1, 1, 0);
    hold(4, 8'hF9);
    check("collide_masked", int_n, 1'b1);
    cycle(8'hF9, 0, 1, 1, 0);
    hold(1, 8'hF9);
    check("collide_unmask", int_n, 1'b0);
    check("collide_opcode", rst_opcode, 8'hD7);
    cycle(8'hF9, 0, 0, 0, 0);
    cycle(8'hFF, 0, 1, 0, 0);
    clear_service();

    // Random traffic, checked by the scoreboard alone
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rnd_req = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 15) == 0) rnd_en = ($urandom_range(0, 3) == 0);
      cycle(rnd_req, rnd_en, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 199) == 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_priority_encoder.md
# irq_priority_encoder

Eight-input priority interrupt encoder, the encoding counterpart of the board's 3-to-8 address decoder. It sits between the active-low peripheral request lines and the 8080 core: it synchronizes the requests, selects the highest pending level, raises the CPU interrupt, and supplies an `RST n` opcode during the acknowledge cycle. It also tracks one in-service level, which masks equal and lower requests until end-of-interrupt.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: request synchronizer depth; legal values are 2 and 3.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `req_n`  in  8  interrupt requests, active low, asynchronous. Bit 7 has the highest priority.
- `en_n`  in  1  encoder enable, active low. Same role as the EI input of a '148.
- `inta_n`  in  1  CPU interrupt acknowledge, active low, synchronous to `clk`.
- `eoi`  in  1  end-of-interrupt, one-cycle pulse. Clears the in-service level.
- `int_n`  out  1  interrupt request to the CPU, active low.
- `code_n`  out  3  registered '148-style encoding of the winning level, inverted.
- `gs_n`  out  1  group select: low when any accepted request is present.
- `eo_n`  out  1  enable out for cascading: low when enabled and no raw request is present.
- `rst_opcode`  out  8  opcode `11 nnn 111`, where nnn is the captured level.
- `opcode_oe`  out  1  high while `rst_opcode` must be driven onto the data bus.

## Operation
- **Synchronizer.** `req_n` passes through `SYNC_STAGES` flops. All synchronizer flops reset to 1.
- **Acceptance.**
  - A synchronized request at level L is accepted if `en_n`=0 and either `in_service_valid`=0 or L > `in_service_level`.
  - The winner is the highest accepted L.
- **Status outputs.** `code_n`, `gs_n` and `eo_n` are registered every cycle from the current accepted set, independent of FSM state.
  - With no accepted request: `code_n`=111 and `gs_n`=1.
  - `eo_n`=0 only when `en_n`=0 and all synchronized `req_n` bits are 1. A request that is pending but masked by the in-service level therefore keeps `eo_n`=1.
- **FSM states:** IDLE, REQ, ACK.
  - IDLE → REQ when the accepted set is non-empty. On this transition the winner is captured into `cap_level` and `int_n` goes to 0.
  - REQ: `cap_level` is frozen. Later higher requests, withdrawal of the request, and `en_n` changes do not alter it. `int_n` stays 0.
  - REQ → ACK on the first cycle `inta_n`=0. In ACK: `int_n`=1 and `opcode_oe`=1.
  - ACK → IDLE on the first cycle `inta_n`=1. On this transition `in_service_level`←`cap_level`, `in_service_valid`←1 and `opcode_oe`←0.
- **Ignored input.** `inta_n`=0 in IDLE is ignored; `opcode_oe` stays 0.
- **End of interrupt.** `eoi` clears `in_service_valid` in any state.
  - If `eoi` coincides with the ACK→IDLE transition, the new level is installed and `in_service_valid`=1.
  - There is no nesting stack: a higher-level interrupt overwrites the in-service level.
- **Opcode.** `rst_opcode` = {2'b11, `cap_level`, 3'b111}, held constant from REQ entry through ACK.

## Timing
- **Reset values** (applied on the clock edge while `reset`=1, regardless of state, including mid-ACK):
  - `int_n`=1, `code_n`=111, `gs_n`=1, `eo_n`=1
  - `rst_opcode`=8'hFF, `opcode_oe`=0
  - `cap_level`=7, `in_service_level`=0, `in_service_valid`=0, state IDLE
- **Request latency:** with `SYNC_STAGES`=2, a `req_n` bit sampled low at edge 0 gives synchronized low after edge 1, and `int_n`=0 after edge 2. `code_n` and `gs_n` update on the same edge as `int_n`.
- **Acknowledge:**
  - `opcode_oe` rises on the edge that samples `inta_n`=0, so it is one cycle after the `inta_n` fall.
  - `opcode_oe` falls on the edge that samples `inta_n`=1.
  - `int_n` returns to 1 on the same edge that `opcode_oe` rises.
- **Re-arm:** the earliest re-raise of `int_n` is the edge after ACK→IDLE. This needs a still-accepted request under the newly installed mask.
- **EOI latency:** an `eoi` pulse at edge k unmasks lower levels. `int_n` can assert at edge k+1.

## Test plan
- **Single request:** after reset, drive `req_n`=8'hFB (level 2). Expect `int_n`=0 two cycles later, `code_n`=3'b101, `gs_n`=0. Pulse `inta_n` low for 2 cycles. Expect `opcode_oe`=1 for 2 cycles, `rst_opcode`=8'hD7, `int_n`=1 during ACK.
- **Priority and freeze:** drive `req_n`=8'h7E (levels 7 and 0). Expect capture of 7 and `rst_opcode`=8'hFF. Then add and remove requests while in REQ: `rst_opcode` must stay 8'hFF.
- **Masking:** with level 5 in service, assert level 3. Expect `int_n`=1, `gs_n`=1, `eo_n`=1. Assert level 6. Expect `int_n`=0 and `rst_opcode`=8'hF7. Pulse `eoi` with level 3 still held. After the level-6 ack, verify level 3 is still masked until the next `eoi`.
- **Enable and cascade:** `en_n`=1 with `req_n`=8'hEF. Expect `int_n`=1, `gs_n`=1, `eo_n`=1. With `en_n`=0 and `req_n`=8'hFF, expect `eo_n`=0.
- **Reset in ACK:** assert `reset` while `opcode_oe`=1. On the next edge, expect every output and internal register at its reset value. Expect the still-held request to re-raise `int_n` 2 cycles after `reset` is released.
- **EOI collision:** `eoi` on the same cycle as the `inta_n` rise. Expect `in_service_valid`=1 with the newly captured level.
